// File: rtl/icmp_echo_rx.sv
// icmp_echo_rx: ICMP echo receive path, with header parse, speculative payload FIFO and meta queue.
// Define ICMP_CHECKSUM_CHECK_EN to drop frames whose ICMP checksum does not verify.
module icmp_echo_rx #(
   parameter int FIFO_DEPTH   = 2048,
   parameter int META_DEPTH   = 4,
   parameter int ACCEPT_REPLY = 0,
   parameter int CNT_W        = 16
) (
   input  logic             rx_mac_aclk,
   input  logic             rx_mac_resetn,
   input  logic [7:0]       rx_ip_proto,
   input  logic [7:0]       rx_axis_ip_tdata,
   input  logic             rx_axis_ip_tvalid,
   input  logic             rx_axis_ip_tlast,
   input  logic [1:0]       rx_axis_ip_tuser,
   input  logic             rx_axis_ip_tdest,
   output logic [7:0]       m_axis_icmp_tdata,
   output logic             m_axis_icmp_tvalid,
   input  logic             m_axis_icmp_tready,
   output logic             m_axis_icmp_tlast,
   output logic             m_icmp_meta_valid,
   input  logic             m_icmp_meta_ready,
   output logic [7:0]       m_icmp_type,
   output logic [7:0]       m_icmp_code,
   output logic [15:0]      m_icmp_id,
   output logic [15:0]      m_icmp_seq,
   output logic [15:0]      m_icmp_len,
   output logic [CNT_W-1:0] stat_rx_good,
   output logic [CNT_W-1:0] stat_rx_drop
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int MW = (META_DEPTH > 1) ? $clog2(META_DEPTH) : 1;

   typedef enum logic [1:0] {IDLE, HDR, PAY, DROP} state_t;

   typedef struct packed {
      logic [7:0]  typ;
      logic [7:0]  code;
      logic [15:0] id;
      logic [15:0] seq;
      logic [15:0] len;
   } meta_t;

   state_t state, state_nx;

   logic          mid;
   logic [3:0]    hcnt;
   logic [7:0]    typ_q;
   logic [7:0]    code_q;
   logic [15:0]   id_q;
   logic [15:0]   seq_q;
   logic [15:0]   plen;
   logic [AW:0]   wr_spec;
   logic [AW:0]   wr_commit;
   logic [AW:0]   end_ptr;
   logic [AW:0]   rd_ptr;
   logic [AW:0]   commit_lim;
   logic          commit_pend;
   meta_t         meta_pend;
   meta_t         meta_new;
   meta_t         mhead;
   logic [MW:0]   mwp;
   logic [MW:0]   mrp;
   logic [MW+1:0] mfill;
   logic [8:0]    rd_word;

   logic [8:0] mem [FIFO_DEPTH];
   meta_t      mq  [2**MW];

   logic beat, sel, start, active, eof;
   logic fifo_full, meta_full, wr_en;
   logic hdr_ok, type_ok, ovf, csum_ok, good, drop, load;

   assign beat   = rx_axis_ip_tvalid;
   assign sel    = rx_axis_ip_tdest && (rx_ip_proto == 8'd1);
   assign start  = beat && !mid && (state == IDLE) && sel;
   assign active = start || (beat && (state != IDLE));
   assign eof    = active && rx_axis_ip_tlast;

   assign fifo_full = (wr_spec[AW] != rd_ptr[AW]) &&
                      (wr_spec[AW-1:0] == rd_ptr[AW-1:0]);
   assign mfill     = {1'b0, mwp - mrp} + (MW+2)'(commit_pend);
   assign meta_full = mfill >= (MW+2)'(META_DEPTH);
   assign wr_en     = beat && (state == PAY) && !fifo_full;

   assign hdr_ok  = (state == PAY) || ((state == HDR) && (hcnt == 4'd7));
   assign type_ok = (typ_q == 8'd8) ||
                    ((ACCEPT_REPLY != 0) && (typ_q == 8'd0));
   assign ovf     = (state == DROP) || ((state == PAY) && fifo_full) ||
                    (start && meta_full);
   assign good    = eof && (rx_axis_ip_tuser == 2'b00) && hdr_ok &&
                    type_ok && csum_ok && !ovf;
   assign drop    = eof && !good;

   assign meta_new.typ  = typ_q;
   assign meta_new.code = code_q;
   assign meta_new.id   = id_q;
   assign meta_new.seq  = (state == HDR) ? {seq_q[15:8], rx_axis_ip_tdata}
                                         : seq_q;
   assign meta_new.len  = plen + 16'(wr_en);

`ifdef ICMP_CHECKSUM_CHECK_EN
   logic [15:0] csum_q;
   logic [15:0] csum_d;
   logic [15:0] csum_add;
   logic [16:0] csum_sum;
   logic        odd_q;

   // even byte positions land in the high half of each 16-bit word
   assign csum_add = (odd_q && !start) ? {8'h00, rx_axis_ip_tdata}
                                       : {rx_axis_ip_tdata, 8'h00};
   assign csum_sum = {1'b0, start ? 16'h0000 : csum_q} + {1'b0, csum_add};
   assign csum_d   = csum_sum[15:0] + 16'(csum_sum[16]);
   assign csum_ok  = (csum_d == 16'hFFFF);

   always_ff @(posedge rx_mac_aclk or negedge rx_mac_resetn) begin
      if (!rx_mac_resetn) begin
         csum_q <= '0;
         odd_q  <= 1'b0;
      end else if (active) begin
         csum_q <= csum_d;
         odd_q  <= start ? 1'b1 : !odd_q;
      end
   end
`else
   assign csum_ok = 1'b1;
`endif

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: if (start)
                  state_nx = rx_axis_ip_tlast ? IDLE :
                             (meta_full ? DROP : HDR);
         HDR:  if (beat)
                  state_nx = rx_axis_ip_tlast ? IDLE :
                             ((hcnt == 4'd7) ? PAY : HDR);
         PAY:  if (beat)
                  state_nx = rx_axis_ip_tlast ? IDLE :
                             (fifo_full ? DROP : PAY);
         DROP: if (beat && rx_axis_ip_tlast)
                  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge rx_mac_aclk or negedge rx_mac_resetn) begin
      if (!rx_mac_resetn) state <= IDLE;
      else                state <= state_nx;
   end

   assign commit_lim = commit_pend ? end_ptr : wr_commit;

   // mid starts set so the tail of a frame cut by reset is skipped
   always_ff @(posedge rx_mac_aclk or negedge rx_mac_resetn) begin
      if (!rx_mac_resetn) begin
         mid          <= 1'b1;
         hcnt         <= '0;
         typ_q        <= '0;
         code_q       <= '0;
         id_q         <= '0;
         seq_q        <= '0;
         plen         <= '0;
         wr_spec      <= '0;
         wr_commit    <= '0;
         end_ptr      <= '0;
         commit_pend  <= 1'b0;
         meta_pend    <= '0;
         mwp          <= '0;
         mrp          <= '0;
         stat_rx_good <= '0;
         stat_rx_drop <= '0;
      end else begin
         if (beat) mid <= !rx_axis_ip_tlast;
         if (start) begin
            typ_q <= rx_axis_ip_tdata;
            hcnt  <= 4'd1;
            plen  <= '0;
         end else if (beat && (state == HDR)) begin
            case (hcnt)
               4'd1:    code_q       <= rx_axis_ip_tdata;
               4'd4:    id_q[15:8]   <= rx_axis_ip_tdata;
               4'd5:    id_q[7:0]    <= rx_axis_ip_tdata;
               4'd6:    seq_q[15:8]  <= rx_axis_ip_tdata;
               4'd7:    seq_q[7:0]   <= rx_axis_ip_tdata;
               default: ;
            endcase
            hcnt <= hcnt + 4'd1;
         end
         if (wr_en) plen <= plen + 16'd1;
         if (drop)       wr_spec <= commit_lim;
         else if (wr_en) wr_spec <= wr_spec + (AW+1)'(1);
         commit_pend <= good;
         if (good) begin
            end_ptr   <= wr_spec + (AW+1)'(wr_en);
            meta_pend <= meta_new;
         end
         if (commit_pend) begin
            wr_commit <= end_ptr;
            mwp       <= mwp + (MW+1)'(1);
            if (stat_rx_good != {CNT_W{1'b1}})
               stat_rx_good <= stat_rx_good + CNT_W'(1);
         end
         if (drop && (stat_rx_drop != {CNT_W{1'b1}}))
            stat_rx_drop <= stat_rx_drop + CNT_W'(1);
         if (m_icmp_meta_valid && m_icmp_meta_ready)
            mrp <= mrp + (MW+1)'(1);
      end
   end

   always_ff @(posedge rx_mac_aclk) begin
      if (wr_en)
         mem[wr_spec[AW-1:0]] <= {rx_axis_ip_tlast, rx_axis_ip_tdata};
      if (commit_pend)
         mq[mwp[MW-1:0]] <= meta_pend;
   end

   assign rd_word = mem[rd_ptr[AW-1:0]];
   assign load    = (rd_ptr != commit_lim) &&
                    (!m_axis_icmp_tvalid || m_axis_icmp_tready);

   always_ff @(posedge rx_mac_aclk or negedge rx_mac_resetn) begin
      if (!rx_mac_resetn) begin
         m_axis_icmp_tvalid <= 1'b0;
         m_axis_icmp_tdata  <= '0;
         m_axis_icmp_tlast  <= 1'b0;
         rd_ptr             <= '0;
      end else if (load) begin
         m_axis_icmp_tvalid <= 1'b1;
         m_axis_icmp_tdata  <= rd_word[7:0];
         m_axis_icmp_tlast  <= rd_word[8];
         rd_ptr             <= rd_ptr + (AW+1)'(1);
      end else if (m_axis_icmp_tready) begin
         m_axis_icmp_tvalid <= 1'b0;
      end
   end

   assign mhead             = mq[mrp[MW-1:0]];
   assign m_icmp_meta_valid = (mwp != mrp);
   assign m_icmp_type = m_icmp_meta_valid ? mhead.typ  : '0;
   assign m_icmp_code = m_icmp_meta_valid ? mhead.code : '0;
   assign m_icmp_id   = m_icmp_meta_valid ? mhead.id   : '0;
   assign m_icmp_seq  = m_icmp_meta_valid ? mhead.seq  : '0;
   assign m_icmp_len  = m_icmp_meta_valid ? mhead.len  : '0;

endmodule

// File: tb/tb_icmp_echo_rx.sv
// tb_icmp_echo_rx: directed frames against a queue model of accepted echo frames.
// Honours ICMP_CHECKSUM_CHECK_EN the same way the design does.
module tb_icmp_echo_rx;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic [7:0]  proto, tdata;
   logic        tvalid, tlast, tdest;
   logic [1:0]  tuser;
   logic [7:0]  o_data;
   logic        o_valid, o_last, tready;
   logic        m_valid, m_ready;
   logic [7:0]  m_type, m_code;
   logic [15:0] m_id, m_seq, m_len;
   logic [15:0] st_good, st_drop;

   icmp_echo_rx #(
      .FIFO_DEPTH(64), .META_DEPTH(4), .ACCEPT_REPLY(0), .CNT_W(16)
   ) dut (
      .rx_mac_aclk(clk), .rx_mac_resetn(rst_n),
      .rx_ip_proto(proto),
      .rx_axis_ip_tdata(tdata), .rx_axis_ip_tvalid(tvalid),
      .rx_axis_ip_tlast(tlast), .rx_axis_ip_tuser(tuser),
      .rx_axis_ip_tdest(tdest),
      .m_axis_icmp_tdata(o_data), .m_axis_icmp_tvalid(o_valid),
      .m_axis_icmp_tready(tready), .m_axis_icmp_tlast(o_last),
      .m_icmp_meta_valid(m_valid), .m_icmp_meta_ready(m_ready),
      .m_icmp_type(m_type), .m_icmp_code(m_code),
      .m_icmp_id(m_id), .m_icmp_seq(m_seq), .m_icmp_len(m_len),
      .stat_rx_good(st_good), .stat_rx_drop(st_drop)
   );

   int total = 0;
   int bad   = 0;
   int m_good = 0;
   int m_drop = 0;
   int pay_seen = 0;
   byte unsigned frm[$];
   logic [63:0] exp_meta[$];
   logic [8:0]  exp_pay[$];
   logic [63:0] last_meta;
   logic [8:0]  last_pay;

   task automatic chk(input string nm, input logic [79:0] act,
                      input logic [79:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, req);
      end
   endtask

   function automatic logic [15:0] osum(input byte unsigned q[$]);
      logic [31:0] s = 0;
      for (int i = 0; i < q.size(); i++)
         s += (i % 2 == 0) ? 32'({q[i], 8'h00}) : 32'(q[i]);
      while (s[31:16] != 0) s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
      return s[15:0];
   endfunction

   task automatic mk(input logic [7:0] ty, input logic [7:0] co,
                     input logic [15:0] id, input logic [15:0] sq,
                     input int n, input logic [7:0] b0);
      logic [15:0] cs;
      frm = {};
      frm.push_back(ty); frm.push_back(co);
      frm.push_back(8'h00); frm.push_back(8'h00);
      frm.push_back(id[15:8]); frm.push_back(id[7:0]);
      frm.push_back(sq[15:8]); frm.push_back(sq[7:0]);
      for (int i = 0; i < n; i++) frm.push_back(8'(b0 + 8'(i)));
      cs = ~osum(frm);
      frm[2] = cs[15:8];
      frm[3] = cs[7:0];
   endtask

   task automatic beat(input logic [7:0] d, input logic l,
                       input logic [1:0] u);
      tvalid = 1'b1; tdata = d; tlast = l; tuser = l ? u : 2'b00;
      @(posedge clk); #1;
      tvalid = 1'b0; tlast = 1'b0; tuser = 2'b00;
   endtask

   task automatic model(input logic dst, input logic [7:0] pr,
                        input logic [1:0] u, input bit ovf);
      int n = frm.size();
      bit ok;
      if (dst && pr == 8'd1) begin
         ok = (u == 2'b00) && (n >= 8) && (frm[0] == 8'd8) && !ovf;
`ifdef ICMP_CHECKSUM_CHECK_EN
         ok = ok && (osum(frm) == 16'hFFFF);
`endif
         if (ok) begin
            exp_meta.push_back({frm[0], frm[1], frm[4], frm[5],
                                frm[6], frm[7], 16'(n - 8)});
            for (int i = 8; i < n; i++)
               exp_pay.push_back({(i == n - 1), frm[i]});
            m_good++;
         end else begin
            m_drop++;
         end
      end
   endtask

   task automatic send(input logic dst, input logic [7:0] pr,
                       input logic [1:0] u, input bit ovf);
      tdest = dst; proto = pr;
      for (int i = 0; i < frm.size(); i++)
         beat(frm[i], (i == frm.size() - 1), u);
      model(dst, pr, u, ovf);
   endtask

   task automatic drain(input string nm);
      int c = 0;
      while ((exp_meta.size() != 0 || exp_pay.size() != 0) && c < 2000) begin
         @(posedge clk);
         c++;
      end
      total++;
      if (c >= 2000) begin
         bad++;
         $display("FAIL %s drain: left meta=%0d pay=%0d want 0 0",
                  nm, exp_meta.size(), exp_pay.size());
      end
      repeat (6) @(posedge clk);
      #1;
   endtask

   task automatic chk_stats(input string nm);
      chk({nm, "_good"}, 80'(st_good), 80'(m_good));
      chk({nm, "_drop"}, 80'(st_drop), 80'(m_drop));
   endtask

   task automatic chk_rst(input string nm);
      chk({nm, "_valid"}, {78'h0, o_valid, m_valid}, 80'h0);
      chk({nm, "_data"}, 80'({o_data, o_last, m_type, m_code,
                               m_id, m_seq, m_len}), 80'h0);
      chk({nm, "_stats"}, 80'({st_good, st_drop}), 80'h0);
   endtask

   logic        pm_hold, pp_hold;
   logic [63:0] pm, mcur;
   logic [8:0]  pp, pcur;

   always @(negedge clk) begin
      if (!rst_n) begin
         pm_hold = 1'b0;
         pp_hold = 1'b0;
      end else begin
         mcur = {m_type, m_code, m_id, m_seq, m_len};
         pcur = {o_last, o_data};
         if (pm_hold) chk("meta_hold", {m_valid, mcur}, {1'b1, pm});
         if (pp_hold) chk("pay_hold", {o_valid, pcur}, {1'b1, pp});
         if (m_valid && m_ready) begin
            if (exp_meta.size() == 0) chk("meta_extra", 80'(mcur), 80'h0);
            else chk("meta", 80'(mcur), 80'(exp_meta.pop_front()));
            last_meta = mcur;
         end
         if (o_valid && tready) begin
            if (exp_pay.size() == 0) chk("pay_extra", 80'(pcur), 80'h0);
            else chk("pay", 80'(pcur), 80'(exp_pay.pop_front()));
            last_pay = pcur;
            pay_seen++;
         end
         pm_hold = m_valid && !m_ready;
         pm      = mcur;
         pp_hold = o_valid && !tready;
         pp      = pcur;
      end
   end

   task automatic sync();
      tdest = 1'b0; proto = 8'd17;
      beat(8'h00, 1'b1, 2'b00);
   endtask

   initial begin
      int d0, g0, p0;
      rst_n = 1'b0; tvalid = 1'b0; tdata = '0; tlast = 1'b0;
      tuser = '0; tdest = 1'b0; proto = '0; tready = 1'b1; m_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk_rst("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;
      sync();

      // basic echo request, plus latency of meta/payload valid
      mk(8'd8, 8'd0, 16'h1234, 16'h0001, 32, 8'h00);
      chk("csum_pin", 80'({frm[2], frm[3]}), 80'h F4C9);
      send(1'b1, 8'd1, 2'b00, 1'b0);
      @(negedge clk);
      chk("lat_early", {78'h0, m_valid, o_valid}, 80'h0);
      @(negedge clk);
      chk("lat_valid", {78'h0, m_valid, o_valid}, 80'h3);
      drain("t028");
      chk("t028_good", 80'(st_good), 80'd1);
      chk("t028_drop", 80'(st_drop), 80'd0);
      chk("t028_meta", 80'(last_meta),
          80'({8'd8, 8'd0, 16'h1234, 16'h0001, 16'd32}));
      chk("t028_last", 80'(last_pay), 80'h11F);
      chk("t028_bytes", 80'(pay_seen), 80'd32);

      // corrupted checksum
      mk(8'd8, 8'd0, 16'h1234, 16'h0001, 32, 8'h00);
      frm[3] = frm[3] ^ 8'h01;
      send(1'b1, 8'd1, 2'b00, 1'b0);
      drain("t029");
`ifdef ICMP_CHECKSUM_CHECK_EN
      chk("t029_drop", 80'(st_drop), 80'd1);
      chk("t029_good", 80'(st_good), 80'd1);
`else
      chk("t029_drop", 80'(st_drop), 80'd0);
      chk("t029_good", 80'(st_good), 80'd2);
`endif
      chk_stats("t029");

      // tuser error then good odd-length frame back-to-back
      mk(8'd8, 8'd0, 16'hAAAA, 16'h0007, 16, 8'h40);
      send(1'b1, 8'd1, 2'b10, 1'b0);
      mk(8'd8, 8'd0, 16'h5678, 16'h0002, 21, 8'hA0);
      send(1'b1, 8'd1, 2'b00, 1'b0);
      drain("t030");
      chk("t030_meta", 80'(last_meta),
          80'({8'd8, 8'd0, 16'h5678, 16'h0002, 16'd21}));
      chk("t030_last", 80'(last_pay), 80'h1B4);
      chk_stats("t030");

      // zero payload frame
      p0 = pay_seen;
      mk(8'd8, 8'd3, 16'h0BAD, 16'h0009, 0, 8'h00);
      send(1'b1, 8'd1, 2'b00, 1'b0);
      drain("t021");
      chk("t021_meta", 80'(last_meta),
          80'({8'd8, 8'd3, 16'h0BAD, 16'h0009, 16'd0}));
      chk("t021_nopay", 80'(pay_seen - p0), 80'd0);

      // runt, echo reply, and a UDP frame
      d0 = st_drop; g0 = st_good;
      mk(8'd8, 8'd0, 16'h0001, 16'h0001, 0, 8'h00);
      frm = frm[0:5];
      send(1'b1, 8'd1, 2'b00, 1'b0);
      mk(8'd0, 8'd0, 16'h0002, 16'h0002, 10, 8'h00);
      send(1'b1, 8'd1, 2'b00, 1'b0);
      mk(8'd8, 8'd0, 16'h0003, 16'h0003, 10, 8'h00);
      send(1'b0, 8'd1, 2'b00, 1'b0);
      drain("t032");
      chk("t032_drop_delta", 80'(int'(st_drop) - d0), 80'd2);
      chk("t032_good_delta", 80'(int'(st_good) - g0), 80'd0);
      chk_stats("t032");

      // overflow with the payload sink stalled
      d0 = st_drop; p0 = pay_seen;
      tready = 1'b0; m_ready = 1'b0;
      mk(8'd8, 8'd0, 16'h0031, 16'h0001, 40, 8'h10);
      send(1'b1, 8'd1, 2'b00, 1'b0);
      mk(8'd8, 8'd0, 16'h0031, 16'h0002, 40, 8'h80);
      send(1'b1, 8'd1, 2'b00, 1'b1);
      repeat (10) @(posedge clk);
      #1;
      chk("t031_stall", 80'(pay_seen - p0), 80'd0);
      chk("t031_drop_delta", 80'(int'(st_drop) - d0), 80'd1);
      tready = 1'b1; m_ready = 1'b1;
      drain("t031");
      chk("t031_bytes", 80'(pay_seen - p0), 80'd40);
      chk("t031_last", 80'(last_pay), 80'h137);
      chk_stats("t031");

      // reset in the middle of a payload
      mk(8'd8, 8'd0, 16'h3333, 16'h0003, 20, 8'h00);
      tdest = 1'b1; proto = 8'd1;
      for (int i = 0; i < 18; i++) beat(frm[i], 1'b0, 2'b00);
      rst_n = 1'b0;
      #1;
      chk_rst("t033_rst");
      m_good = 0; m_drop = 0;
      exp_meta = {}; exp_pay = {};
      @(posedge clk); #1;
      chk_rst("t033_hold");
      rst_n = 1'b1;
      @(posedge clk); #1;
      for (int i = 18; i < frm.size(); i++)
         beat(frm[i], (i == frm.size() - 1), 2'b00);
      mk(8'd8, 8'd0, 16'h4444, 16'h0004, 12, 8'h60);
      send(1'b1, 8'd1, 2'b00, 1'b0);
      drain("t033");
      chk("t033_good", 80'(st_good), 80'd1);
      chk("t033_drop", 80'(st_drop), 80'd0);
      chk("t033_meta", 80'(last_meta),
          80'({8'd8, 8'd0, 16'h4444, 16'h0004, 16'd12}));
      chk("t033_last", 80'(last_pay), 80'h16B);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
